// File: rtl/fft_frame_buffer_if.sv
// Stream bundle for fft_frame_buffer: FFT sample input + drain output.
// slave: buffer side; master: FFT source / UART packer side.
interface fft_frame_buffer_if #(
  parameter int DATA_W = 32
);
  logic              data_valid;
  logic              data_sop;
  logic [DATA_W-1:0] data_in;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  data_valid, data_sop, data_in, out_ready,
    output out_valid, out_data, out_last
  );

  modport master (
    output data_valid, data_sop, data_in, out_ready,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_frame_buffer.sv
// Arms on rx_ready, captures one FFT frame (optionally decimated) into RAM,
// then drains it as a valid/ready stream with last marker.
// Ports: clk, rst_n (async low), rx_ready; bus (slave: data_valid,
// data_sop, data_in, out_ready -> out_valid, out_data, out_last);
// tx_ready, uart_en, frame_cnt[7:0], overrun.
module fft_frame_buffer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int DECIM      = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_ready,
  fft_frame_buffer_if.slave   bus,
  output logic                tx_ready,
  output logic                uart_en,
  output logic [7:0]          frame_cnt,
  output logic                overrun
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FILL,
    S_DRAIN,
    S_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [3:0]        DMAX = 4'(DECIM - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        dec_cnt;
  logic              rd_done;
  logic              sop_in;
  logic              we;
  logic              fill_end;
  logic              load;
  logic              xfer;
  logic              xfer_last;

  function automatic logic [3:0] dnext(input logic [3:0] c);
    return (c == DMAX) ? 4'd0 : c + 4'd1;
  endfunction

  assign sop_in    = bus.data_valid & bus.data_sop;
  assign xfer      = bus.out_valid & bus.out_ready;
  assign xfer_last = xfer & bus.out_last;
  assign fill_end  = we & (waddr == LAST);

  // Prefetch: read the next word whenever the output register is
  // empty or being emptied this cycle.
  assign load = (state == S_DRAIN) & ~rd_done
              & (~bus.out_valid | bus.out_ready);

  assign uart_en  = (state == S_DRAIN);
  assign tx_ready = (state == S_IDLE) | (state == S_ARM);

  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr;
    if (rx_ready) begin
      if ((state == S_ARM || state == S_FILL) && sop_in) begin
        we    = 1'b1;
        waddr = '0;
      end else if (state == S_FILL && bus.data_valid
                   && dec_cnt == 4'd0) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (rx_ready) state_d = S_ARM;
      S_ARM: begin
        if (!rx_ready)   state_d = S_IDLE;
        else if (sop_in) state_d = S_FILL;
      end
      S_FILL: begin
        if (!rx_ready)     state_d = S_IDLE;
        else if (fill_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (xfer_last) begin
          if (!rx_ready)            state_d = S_IDLE;
          else if (CONTINUOUS != 0) state_d = S_ARM;
          else                      state_d = S_WAIT;
        end else if (!rx_ready) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT:  if (!rx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_done       <= 1'b0;
      dec_cnt       <= 4'd0;
      overrun       <= 1'b0;
      frame_cnt     <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (state == S_IDLE && rx_ready) overrun <= 1'b0;
      if (state == S_FILL && rx_ready && sop_in) overrun <= 1'b1;

      if (we) wr_ptr <= (waddr == LAST) ? '0 : waddr + 1'b1;

      if (rx_ready && sop_in
          && (state == S_ARM || state == S_FILL))
        dec_cnt <= dnext(4'd0);
      else if (rx_ready && state == S_FILL && bus.data_valid)
        dec_cnt <= dnext(dec_cnt);

      if (xfer_last) frame_cnt <= frame_cnt + 8'd1;

      // Leaving (or not in) DRAIN: flush the output stage and
      // rewind the read side for the next frame.
      if (state_d != S_DRAIN) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        rd_ptr        <= '0;
        rd_done       <= 1'b0;
      end else if (load) begin
        bus.out_data  <= mem[rd_ptr];
        bus.out_valid <= 1'b1;
        bus.out_last  <= (rd_ptr == LAST);
        if (rd_ptr == LAST) rd_done <= 1'b1;
        else                rd_ptr  <= rd_ptr + 1'b1;
      end else if (xfer) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Testbench for fft_frame_buffer: three configurations share stimulus,
// each scenario checks the selected instance against a frame model.
module tb_fft_frame_buffer;
  localparam int FL = 8;

  logic        clk;
  logic        rst_n;
  logic        rx_ready;
  logic        data_valid;
  logic        data_sop;
  logic [31:0] data_in;
  logic        out_ready;

  logic       tx0, ue0, or0, tx1, ue1, or1, tx2, ue2, or2;
  logic [7:0] fc0, fc1, fc2;

  fft_frame_buffer_if #(.DATA_W(32)) b0 ();
  fft_frame_buffer_if #(.DATA_W(32)) b1 ();
  fft_frame_buffer_if #(.DATA_W(32)) b2 ();

  assign b0.data_valid = data_valid;
  assign b0.data_sop   = data_sop;
  assign b0.data_in    = data_in;
  assign b0.out_ready  = out_ready;
  assign b1.data_valid = data_valid;
  assign b1.data_sop   = data_sop;
  assign b1.data_in    = data_in;
  assign b1.out_ready  = out_ready;
  assign b2.data_valid = data_valid;
  assign b2.data_sop   = data_sop;
  assign b2.data_in    = data_in;
  assign b2.out_ready  = out_ready;

  fft_frame_buffer #(
    .DATA_W(32), .ADDR_W(3), .FRAME_LEN(FL),
    .DECIM(1), .CONTINUOUS(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .bus(b0),
    .tx_ready(tx0), .uart_en(ue0), .frame_cnt(fc0), .overrun(or0)
  );

  fft_frame_buffer #(
    .DATA_W(32), .ADDR_W(4), .FRAME_LEN(FL),
    .DECIM(2), .CONTINUOUS(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .bus(b1),
    .tx_ready(tx1), .uart_en(ue1), .frame_cnt(fc1), .overrun(or1)
  );

  fft_frame_buffer #(
    .DATA_W(32), .ADDR_W(4), .FRAME_LEN(FL),
    .DECIM(1), .CONTINUOUS(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .bus(b2),
    .tx_ready(tx2), .uart_en(ue2), .frame_cnt(fc2), .overrun(or2)
  );

  int          sel;
  logic        ov, ol, tx, ue, orun;
  logic [31:0] od;
  logic [7:0]  fc;

  always_comb begin
    ov = b0.out_valid; od = b0.out_data; ol = b0.out_last;
    tx = tx0; ue = ue0; fc = fc0; orun = or0;
    if (sel == 1) begin
      ov = b1.out_valid; od = b1.out_data; ol = b1.out_last;
      tx = tx1; ue = ue1; fc = fc1; orun = or1;
    end else if (sel == 2) begin
      ov = b2.out_valid; od = b2.out_data; ol = b2.out_last;
      tx = tx2; ue = ue2; fc = fc2; orun = or2;
    end
  end

  int tests_run;
  int tests_failed;

  logic [31:0] src_q[$];
  bit          sop_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          last_q[$];
  int          cyc_q[$];
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfers are observed mid-cycle; they complete at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && ov && out_ready) begin
      got_q.push_back(od);
      last_q.push_back(ol);
      cyc_q.push_back(cyc);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Stored frame: the first FL decimated samples after the latest sop.
  function automatic void model(input int dec);
    int k;
    k = 0;
    exp_q.delete();
    foreach (src_q[i]) begin
      if (exp_q.size() == FL) break;
      if (sop_q[i]) begin
        exp_q.delete();
        k = 0;
      end
      if (k % dec == 0) exp_q.push_back(src_q[i]);
      k++;
    end
  endfunction

  function automatic int frame_diff();
    int d;
    d = (got_q.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        if (got_q[i] !== exp_q[i]) d++;
        if (last_q[i] !== (i == exp_q.size() - 1)) d++;
      end
    end
    return d;
  endfunction

  task automatic new_frame(input int n, input bit seq);
    src_q.delete();
    sop_q.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back(seq ? 32'(i) : $urandom);
      sop_q.push_back(i == 0);
    end
  endtask

  task automatic send(input bit gaps);
    foreach (src_q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        data_valid = 1'b0;
        data_sop   = 1'($urandom_range(0, 1));
        data_in    = $urandom;
        cycle();
      end
      data_valid = 1'b1;
      data_sop   = sop_q[i];
      data_in    = src_q[i];
      cycle();
    end
    data_valid = 1'b0;
    data_sop   = 1'b0;
  endtask

  task automatic drain(input int mode, input int n, output bit to);
    int c;
    c  = 0;
    to = 1'b0;
    while (got_q.size() < n) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'(c % 2);
      else                out_ready = 1'($urandom_range(0, 1));
      cycle();
      c++;
      if (c > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    last_q.delete();
    cyc_q.delete();
  endtask

  task automatic reset_dut();
    rst_n      = 1'b0;
    rx_ready   = 1'b0;
    data_valid = 1'b0;
    data_sop   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    clear_got();
  endtask

  task automatic test_reset();
    reset_dut();
    sel = 0;
    tests_run++;
    if ({ov, ol, ue, orun} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 0000", {ov, ol, ue, orun});
    end
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tx_ready: got %b want 1", tx);
    end
    tests_run++;
    if (fc !== 8'd0 || od !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt_data: got %0d/%0h want 0/0", fc, od);
    end
  endtask

  task automatic test_basic();
    bit to;
    int d;
    reset_dut();
    sel = 0;
    new_frame(FL, 1'b1);
    model(1);
    out_ready = 1'b1;
    rx_ready  = 1'b1;
    cycle();
    send(1'b0);
    tests_run++;
    if ({ue, tx, ov} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_drain_entry: got %b want 100", {ue, tx, ov});
    end
    drain(0, FL, to);
    tests_run++;
    if (to !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_timeout: got %0d want %0d", got_q.size(), FL);
    end
    d = frame_diff();
    tests_run++;
    if (d !== 0) begin
      tests_failed++;
      $display("FAIL basic_frame: got %0d diffs want 0", d);
    end
    tests_run++;
    if (cyc_q.size() == FL && cyc_q[FL-1] - cyc_q[0] !== FL - 1) begin
      tests_failed++;
      $display("FAIL basic_b2b: got span %0d want %0d",
               cyc_q[FL-1] - cyc_q[0], FL - 1);
    end
    tests_run++;
    if (fc !== 8'd1 || orun !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_cnt: got %0d/%b want 1/0", fc, orun);
    end
    tests_run++;
    if ({ov, tx} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_wait_low: got %b want 00", {ov, tx});
    end
    rx_ready = 1'b0;
    cycle();
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_idle: got %b want 1", tx);
    end
  endtask

  task automatic test_decim();
    bit to;
    int d;
    reset_dut();
    sel = 1;
    new_frame(2 * FL, 1'b1);
    model(2);
    out_ready = 1'b1;
    rx_ready  = 1'b1;
    cycle();
    send(1'b1);
    drain(0, FL, to);
    d = frame_diff();
    tests_run++;
    if (to !== 1'b0 || d !== 0) begin
      tests_failed++;
      $display("FAIL decim_frame: got to=%b diffs=%0d want 0/0", to, d);
    end
    tests_run++;
    if (fc !== 8'd1) begin
      tests_failed++;
      $display("FAIL decim_cnt: got %0d want 1", fc);
    end
  endtask

  task automatic test_stall();
    bit          held_v;
    logic [31:0] held_d;
    int          d;
    reset_dut();
    sel = 0;
    new_frame(FL, 1'b0);
    model(1);
    rx_ready = 1'b1;
    cycle();
    send(1'b0);
    held_v = 1'b0;
    held_d = '0;
    for (int c = 0; c < 100 && got_q.size() < FL; c++) begin
      if (held_v) begin
        tests_run++;
        if (ov !== 1'b1 || od !== held_d) begin
          tests_failed++;
          $display("FAIL stall_hold: got %b/%0h want 1/%0h",
                   ov, od, held_d);
        end
      end
      out_ready = 1'(c % 2);
      held_v    = ov && !out_ready;
      held_d    = od;
      cycle();
    end
    d = frame_diff();
    tests_run++;
    if (d !== 0) begin
      tests_failed++;
      $display("FAIL stall_frame: got %0d diffs want 0", d);
    end
    tests_run++;
    if (fc !== 8'd1) begin
      tests_failed++;
      $display("FAIL stall_cnt: got %0d want 1", fc);
    end
  endtask

  task automatic test_overrun();
    bit to;
    int d;
    reset_dut();
    sel = 0;
    new_frame(4, 1'b0);
    for (int i = 0; i < FL; i++) begin
      src_q.push_back($urandom);
      sop_q.push_back(i == 0);
    end
    model(1);
    out_ready = 1'b1;
    rx_ready  = 1'b1;
    cycle();
    send(1'b0);
    drain(0, FL, to);
    d = frame_diff();
    tests_run++;
    if (to !== 1'b0 || d !== 0) begin
      tests_failed++;
      $display("FAIL ovr_frame: got to=%b diffs=%0d want 0/0", to, d);
    end
    tests_run++;
    if (orun !== 1'b1 || fc !== 8'd1) begin
      tests_failed++;
      $display("FAIL ovr_flag: got %b/%0d want 1/1", orun, fc);
    end
    rx_ready = 1'b0;
    cycle();
    tests_run++;
    if (orun !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_sticky: got %b want 1", orun);
    end
    rx_ready = 1'b1;
    cycle();
    tests_run++;
    if (orun !== 1'b0 || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_clear: got %b/%b want 0/1", orun, tx);
    end
  endtask

  task automatic test_abort();
    bit to;
    int d;
    reset_dut();
    sel = 0;
    new_frame(4, 1'b0);
    out_ready = 1'b1;
    rx_ready  = 1'b1;
    cycle();
    send(1'b0);
    rx_ready = 1'b0;
    cycle();
    tests_run++;
    if ({tx, ov, ue} !== 3'b100 || fc !== 8'd0) begin
      tests_failed++;
      $display("FAIL abort_fill: got %b/%0d want 100/0",
               {tx, ov, ue}, fc);
    end
    new_frame(FL, 1'b0);
    model(1);
    rx_ready = 1'b1;
    cycle();
    send(1'b0);
    drain(0, 3, to);
    rx_ready = 1'b0;
    cycle();
    tests_run++;
    if ({tx, ov, ol, ue} !== 4'b1000 || fc !== 8'd0) begin
      tests_failed++;
      $display("FAIL abort_drain: got %b/%0d want 1000/0",
               {tx, ov, ol, ue}, fc);
    end
    tests_run++;
    if (to || got_q.size() < 3 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL abort_partial: got n=%0d want >=3 from new frame",
               got_q.size());
    end
    clear_got();
    new_frame(FL, 1'b0);
    model(1);
    rx_ready = 1'b1;
    cycle();
    send(1'b0);
    drain(0, FL, to);
    d = frame_diff();
    tests_run++;
    if (to !== 1'b0 || d !== 0 || fc !== 8'd1) begin
      tests_failed++;
      $display("FAIL abort_refill: got to=%b diffs=%0d cnt=%0d want 0/0/1",
               to, d, fc);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d;
    reset_dut();
    sel = 2;
    rx_ready = 1'b1;
    cycle();
    for (int f = 0; f < 3; f++) begin
      clear_got();
      new_frame(FL, 1'b0);
      model(1);
      send(1'b1);
      drain(2, FL, to);
      d = frame_diff();
      tests_run++;
      if (to !== 1'b0 || d !== 0) begin
        tests_failed++;
        $display("FAIL cont_frame%0d: got to=%b diffs=%0d want 0/0",
                 f, to, d);
      end
      tests_run++;
      if (tx !== 1'b1 || fc !== 8'(f + 1)) begin
        tests_failed++;
        $display("FAIL cont_rearm%0d: got %b/%0d want 1/%0d",
                 f, tx, fc, f + 1);
      end
    end
    clear_got();
    new_frame(FL, 1'b0);
    send(1'b0);
    drain(0, 3, to);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ov, ol, ue, orun, tx} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL cont_async_rst: got %b want 00001",
               {ov, ol, ue, orun, tx});
    end
    tests_run++;
    if (fc !== 8'd0 || od !== 32'd0) begin
      tests_failed++;
      $display("FAIL cont_rst_cnt: got %0d/%0h want 0/0", fc, od);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    sel          = 0;
    test_reset();
    test_basic();
    test_decim();
    test_stall();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
